// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared iterative multiplier.
// Holds one request in flight and hands the multiplier result back to its owner.
module mul_arbiter #(
  parameter int unsigned SINGLE_CYCLE_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [63:0] req_first_operand_i,
  input  logic [63:0] req_second_operand_i,
  input  logic [3:0]  req_op_i,
  output logic        rsp_valid_o,
  output logic        rsp_id_o,
  output logic [31:0] rsp_result_o,
  input  logic        rsp_ready_i,
  output logic        busy_o,
  output logic        mul_enable_o,
  output logic [31:0] mul_first_operand_o,
  output logic [31:0] mul_second_operand_o,
  output logic [1:0]  mul_signed_mode_o,
  output logic        mul_low_o,
  output logic        mul_single_cycle_o,
  output logic        mul_stall_o,
  input  logic        mul_hold_i,
  input  logic [31:0] mul_result_i
);

  typedef enum logic [1:0] {
    DRAIN = 2'd0,
    IDLE  = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;
  localparam logic [2:0] DRAIN_CYCLES = 3'd4;

  function automatic logic [1:0] op_signed_mode(input logic [1:0] op);
    logic [1:0] mode;
    case (op)
      OP_MUL:    mode = 2'b00;
      OP_MULH:   mode = 2'b11;
      OP_MULHSU: mode = 2'b01;
      OP_MULHU:  mode = 2'b00;
      default:   mode = 2'b00;
    endcase
    return mode;
  endfunction

  function automatic logic op_is_low(input logic [1:0] op);
    return (op == OP_MUL);
  endfunction

  // The fast path is only exact when both operands fit in 16 bits.
  function automatic logic fast_path_ok(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    return (SINGLE_CYCLE_EN != 0) && (op == OP_MUL) &&
           (a[31:16] == 16'h0000) && (b[31:16] == 16'h0000);
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic        busy_q, busy_d;
  logic        mul_en_q, mul_en_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [1:0]  signed_mode_q, signed_mode_d;
  logic        low_q, low_d;
  logic        single_q, single_d;

  logic        any_valid_s;
  logic        grant_s;
  logic        accept_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  logic [1:0]  sel_op_s;
  logic        rsp_valid_s;
  logic        rsp_fire_s;

  // Round-robin grant and operand select for the requester that would win now.
  always_comb begin
    any_valid_s = |req_valid_i;
    case (req_valid_i)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_q;
      default: grant_s = 1'b0;
    endcase
    if (grant_s) begin
      sel_a_s  = req_first_operand_i[63:32];
      sel_b_s  = req_second_operand_i[63:32];
      sel_op_s = req_op_i[3:2];
    end else begin
      sel_a_s  = req_first_operand_i[31:0];
      sel_b_s  = req_second_operand_i[31:0];
      sel_op_s = req_op_i[1:0];
    end
    accept_s = (state_q == IDLE) && any_valid_s;
    if (accept_s) begin
      req_ready_o = grant_s ? 2'b10 : 2'b01;
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Response handshake; result and id are forced to zero when nothing is valid.
  always_comb begin
    rsp_valid_s = (state_q == RUN) && !mul_hold_i;
    rsp_fire_s  = rsp_valid_s && rsp_ready_i;
    if (rsp_valid_s) begin
      rsp_result_o = mul_result_i;
      rsp_id_o     = id_q;
    end else begin
      rsp_result_o = 32'h0000_0000;
      rsp_id_o     = 1'b0;
    end
    rsp_valid_o = rsp_valid_s;
    mul_stall_o = rsp_valid_s && !rsp_ready_i;
  end

  // Next-state logic for the DRAIN/IDLE/RUN sequence and the request registers.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    last_grant_d  = last_grant_q;
    id_d          = id_q;
    mul_en_d      = mul_en_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    signed_mode_d = signed_mode_q;
    low_d         = low_q;
    single_d      = single_q;
    case (state_q)
      DRAIN: begin
        if (drain_cnt_q <= 3'd1) begin
          drain_cnt_d = 3'd0;
          state_d     = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - 3'd1;
          state_d     = DRAIN;
        end
      end
      IDLE: begin
        if (accept_s) begin
          state_d       = RUN;
          last_grant_d  = grant_s;
          id_d          = grant_s;
          mul_en_d      = 1'b1;
          op_a_d        = sel_a_s;
          op_b_d        = sel_b_s;
          signed_mode_d = op_signed_mode(sel_op_s);
          low_d         = op_is_low(sel_op_s);
          single_d      = fast_path_ok(sel_op_s, sel_a_s, sel_b_s);
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Controls drop to zero together with the return to IDLE.
        if (rsp_fire_s) begin
          state_d       = IDLE;
          id_d          = 1'b0;
          mul_en_d      = 1'b0;
          op_a_d        = 32'h0000_0000;
          op_b_d        = 32'h0000_0000;
          signed_mode_d = 2'b00;
          low_d         = 1'b0;
          single_d      = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d       = DRAIN;
        drain_cnt_d   = DRAIN_CYCLES;
        last_grant_d  = 1'b1;
        id_d          = 1'b0;
        mul_en_d      = 1'b0;
        op_a_d        = 32'h0000_0000;
        op_b_d        = 32'h0000_0000;
        signed_mode_d = 2'b00;
        low_d         = 1'b0;
        single_d      = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State registers with synchronous reset into DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= DRAIN;
      drain_cnt_q   <= DRAIN_CYCLES;
      last_grant_q  <= 1'b1;
      id_q          <= 1'b0;
      busy_q        <= 1'b1;
      mul_en_q      <= 1'b0;
      op_a_q        <= 32'h0000_0000;
      op_b_q        <= 32'h0000_0000;
      signed_mode_q <= 2'b00;
      low_q         <= 1'b0;
      single_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      last_grant_q  <= last_grant_d;
      id_q          <= id_d;
      busy_q        <= busy_d;
      mul_en_q      <= mul_en_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      signed_mode_q <= signed_mode_d;
      low_q         <= low_d;
      single_q      <= single_d;
    end
  end

  assign busy_o               = busy_q;
  assign mul_enable_o         = mul_en_q;
  assign mul_first_operand_o  = op_a_q;
  assign mul_second_operand_o = op_b_q;
  assign mul_signed_mode_o    = signed_mode_q;
  assign mul_low_o            = low_q;
  assign mul_single_cycle_o   = single_q;

endmodule
